mult_div_unit: RTL and testbench

Sequential signed multiply/divide unit for the multicycle datapath, sitting directly downstream of the control unit. The control unit fires a one-cycle start pulse, holds its state machine in a wait state until `Pronto`, and then reads `Hi`/`Lo` into the register file. Multiplication uses radix-2 Booth. Division uses restoring division on magnitudes with a sign fix-up, giving MIPS `mult`/`div` semantics.

---
 rtl/mult_div_unit_if.sv | 22 ++
 rtl/mult_div_unit.sv | 137 +++++++++++++
 tb/tb_mult_div_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - operand/start/result bundle between the control unit and mult_div_unit
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             IniciaMult;
  logic             IniciaDiv;
  logic             Ocupado;
  logic             Pronto;
  logic             DivZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output A, B, IniciaMult, IniciaDiv,
    input  Ocupado, Pronto, DivZero, Hi, Lo
  );

  modport slave (
    input  A, B, IniciaMult, IniciaDiv,
    output Ocupado, Pronto, DivZero, Hi, Lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - sequential signed multiply (radix-2 Booth) / restoring divide unit
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic           clock,
  input logic           reset,
  mult_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {OCIOSO, MULT, DIV, FIM} stateType;

  stateType         state, nextState;
  logic [CW-1:0]    counter;
  // acc and mcand carry one extra bit so subtracting the most-negative multiplicand cannot overflow
  logic [WIDTH:0]   acc, mcand;
  logic [WIDTH-1:0] mq;
  logic             qm1, negQuo, negRem;
  logic [WIDTH-1:0] hiReg, loReg;
  logic             divZeroReg;

  logic             startMult, startDiv, startDivZero, lastIter;
  logic [WIDTH:0]   boothSum, multAcc, divShift, divRem;
  logic [WIDTH-1:0] multMq, quoNext, absA, absB;
  logic             divFits;

  always_comb begin
    startMult    = (state == OCIOSO) && bus.IniciaMult;
    startDiv     = (state == OCIOSO) && !bus.IniciaMult && bus.IniciaDiv && (bus.B != '0);
    startDivZero = (state == OCIOSO) && !bus.IniciaMult && bus.IniciaDiv && (bus.B == '0);
    lastIter     = (counter == CW'(1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= OCIOSO;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      OCIOSO: begin
        if (startMult)         nextState = MULT;
        else if (startDiv)     nextState = DIV;
        else if (startDivZero) nextState = FIM;
      end
      MULT:    if (lastIter) nextState = FIM;
      DIV:     if (lastIter) nextState = FIM;
      FIM:     nextState = OCIOSO;
      default: nextState = OCIOSO;
    endcase
  end

  always_comb begin
    absA = bus.A[WIDTH-1] ? -bus.A : bus.A;
    absB = bus.B[WIDTH-1] ? -bus.B : bus.B;

    boothSum = acc;
    case ({mq[0], qm1})
      2'b01:   boothSum = acc + mcand;
      2'b10:   boothSum = acc - mcand;
      default: boothSum = acc;
    endcase
    multAcc = {boothSum[WIDTH], boothSum[WIDTH:1]};
    multMq  = {boothSum[0], mq[WIDTH-1:1]};

    // During DIV, acc holds the remainder and mcand holds {0, |B|}
    divShift = {acc[WIDTH-1:0], mq[WIDTH-1]};
    divFits  = (divShift >= mcand);
    divRem   = divFits ? (divShift - mcand) : divShift;
    quoNext  = {mq[WIDTH-2:0], divFits};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter    <= '0;
      acc        <= '0;
      mcand      <= '0;
      mq         <= '0;
      qm1        <= 1'b0;
      negQuo     <= 1'b0;
      negRem     <= 1'b0;
      hiReg      <= '0;
      loReg      <= '0;
      divZeroReg <= 1'b0;
    end else begin
      case (state)
        OCIOSO: begin
          if (startMult) begin
            acc        <= '0;
            mq         <= bus.B;
            qm1        <= 1'b0;
            mcand      <= {bus.A[WIDTH-1], bus.A};
            counter    <= CW'(WIDTH);
            divZeroReg <= 1'b0;
          end else if (startDiv) begin
            acc        <= '0;
            mq         <= absA;
            mcand      <= {1'b0, absB};
            negQuo     <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
            negRem     <= bus.A[WIDTH-1];
            counter    <= CW'(WIDTH);
            divZeroReg <= 1'b0;
          end else if (startDivZero) begin
            divZeroReg <= 1'b1;
          end
        end
        MULT: begin
          acc     <= multAcc;
          mq      <= multMq;
          qm1     <= mq[0];
          counter <= counter - CW'(1);
          if (lastIter) begin
            hiReg <= multAcc[WIDTH-1:0];
            loReg <= multMq;
          end
        end
        DIV: begin
          acc     <= divRem;
          mq      <= quoNext;
          counter <= counter - CW'(1);
          if (lastIter) begin
            hiReg <= negRem ? -divRem[WIDTH-1:0] : divRem[WIDTH-1:0];
            loReg <= negQuo ? -quoNext : quoNext;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Ocupado = (state == MULT) || (state == DIV);
  assign bus.Pronto  = (state == FIM);
  assign bus.DivZero = divZeroReg;
  assign bus.Hi      = hiReg;
  assign bus.Lo      = loReg;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   totalChecks = 0;
  int   badChecks = 0;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Stimulus only: fires a start in the current (negedge-entered) cycle and watches until Pronto plus extra cycles.
  task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic doMult, input logic doDiv,
                       input int injectDivAt, input int extra,
                       output int latency, output int ocupadoCnt, output int prontoCnt, output logic dzAt1);
    int cyc;
    bus.A = a;
    bus.B = b;
    bus.IniciaMult = doMult;
    bus.IniciaDiv = doDiv;
    latency = -1;
    ocupadoCnt = 0;
    prontoCnt = 0;
    dzAt1 = 1'b0;
    cyc = 0;
    while (cyc < 120 && (latency < 0 || cyc <= latency + 1 + extra)) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        bus.IniciaMult = 1'b0;
        bus.IniciaDiv = 1'b0;
        bus.A = ~a;
        bus.B = ~b;
        dzAt1 = bus.DivZero;
      end
      if (injectDivAt > 0 && cyc == injectDivAt) bus.IniciaDiv = 1'b1;
      if (injectDivAt > 0 && cyc == injectDivAt + 1) bus.IniciaDiv = 1'b0;
      if (bus.Ocupado) ocupadoCnt++;
      if (bus.Pronto) begin
        prontoCnt++;
        if (latency < 0) latency = cyc;
      end
    end
  endtask

  task automatic test_reset();
    totalChecks++;
    if (bus.Hi !== 32'h0 || bus.Lo !== 32'h0) begin
      badChecks++;
      $display("FAIL reset_hilo: Hi=%h Lo=%h required 0/0", bus.Hi, bus.Lo);
    end
    totalChecks++;
    if ({bus.Ocupado, bus.Pronto, bus.DivZero} !== 3'b000) begin
      badChecks++;
      $display("FAIL reset_flags: Ocupado/Pronto/DivZero=%b required 000", {bus.Ocupado, bus.Pronto, bus.DivZero});
    end
  endtask

  task automatic test_mult();
    int lat, ocu, pr;
    logic dz;
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] eh [4];
    logic [31:0] el [4];
    va = '{32'd7, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFB};
    vb = '{32'hFFFFFFFD, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFA};
    eh = '{32'hFFFFFFFF, 32'h40000000, 32'h3FFFFFFF, 32'h00000000};
    el = '{32'hFFFFFFEB, 32'h00000000, 32'h00000001, 32'h0000001E};
    for (int i = 0; i < 4; i++) begin
      runOp(va[i], vb[i], 1'b1, 1'b0, 0, 0, lat, ocu, pr, dz);
      totalChecks++;
      if (bus.Hi !== eh[i] || bus.Lo !== el[i]) begin
        badChecks++;
        $display("FAIL mult_%0d: Hi=%h Lo=%h required %h %h", i, bus.Hi, bus.Lo, eh[i], el[i]);
      end
      totalChecks++;
      if (lat !== 33 || ocu !== 32 || pr !== 1) begin
        badChecks++;
        $display("FAIL mult_timing_%0d: latency=%0d ocupado=%0d pronto=%0d required 33 32 1", i, lat, ocu, pr);
      end
    end
  endtask

  task automatic test_div();
    int lat, ocu, pr;
    logic dz;
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] eh [4];
    logic [31:0] el [4];
    va = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd100};
    vb = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd7};
    eh = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000002};
    el = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'h0000000E};
    for (int i = 0; i < 4; i++) begin
      runOp(va[i], vb[i], 1'b0, 1'b1, 0, 0, lat, ocu, pr, dz);
      totalChecks++;
      if (bus.Hi !== eh[i] || bus.Lo !== el[i] || bus.DivZero !== 1'b0) begin
        badChecks++;
        $display("FAIL div_%0d: Hi=%h Lo=%h DivZero=%b required %h %h 0", i, bus.Hi, bus.Lo, bus.DivZero, eh[i], el[i]);
      end
      totalChecks++;
      if (lat !== 33 || ocu !== 32 || pr !== 1) begin
        badChecks++;
        $display("FAIL div_timing_%0d: latency=%0d ocupado=%0d pronto=%0d required 33 32 1", i, lat, ocu, pr);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, ocu, pr;
    logic dz;
    runOp(32'd6, 32'd7, 1'b1, 1'b0, 0, 0, lat, ocu, pr, dz);
    runOp(32'd5, 32'd0, 1'b0, 1'b1, 0, 0, lat, ocu, pr, dz);
    totalChecks++;
    if (bus.DivZero !== 1'b1 || bus.Hi !== 32'd0 || bus.Lo !== 32'd42) begin
      badChecks++;
      $display("FAIL divzero_result: DivZero=%b Hi=%h Lo=%h required 1 0 0000002a", bus.DivZero, bus.Hi, bus.Lo);
    end
    totalChecks++;
    if (lat !== 1 || ocu !== 0 || pr !== 1) begin
      badChecks++;
      $display("FAIL divzero_timing: latency=%0d ocupado=%0d pronto=%0d required 1 0 1", lat, ocu, pr);
    end
    runOp(32'd2, 32'd3, 1'b1, 1'b0, 0, 0, lat, ocu, pr, dz);
    totalChecks++;
    if (dz !== 1'b0 || bus.Lo !== 32'd6 || bus.DivZero !== 1'b0) begin
      badChecks++;
      $display("FAIL divzero_clear: DivZeroAfterAccept=%b Lo=%h required 0 00000006", dz, bus.Lo);
    end
  endtask

  task automatic test_overlap();
    int lat, ocu, pr;
    logic dz;
    runOp(32'd9, 32'd5, 1'b1, 1'b1, 0, 0, lat, ocu, pr, dz);
    totalChecks++;
    if (bus.Hi !== 32'd0 || bus.Lo !== 32'd45 || lat !== 33) begin
      badChecks++;
      $display("FAIL overlap_both: Hi=%h Lo=%h latency=%0d required 0 0000002d 33", bus.Hi, bus.Lo, lat);
    end
    runOp(32'd11, 32'd13, 1'b1, 1'b0, 10, 40, lat, ocu, pr, dz);
    totalChecks++;
    if (bus.Hi !== 32'd0 || bus.Lo !== 32'd143 || pr !== 1 || ocu !== 32) begin
      badChecks++;
      $display("FAIL overlap_ignored: Hi=%h Lo=%h pronto=%0d ocupado=%0d required 0 0000008f 1 32", bus.Hi, bus.Lo, pr, ocu);
    end
  endtask

  task automatic test_reset_mid();
    int lat, ocu, pr;
    logic dz;
    int late;
    bus.A = 32'd1000;
    bus.B = 32'd1000;
    bus.IniciaMult = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      bus.IniciaMult = 1'b0;
    end
    totalChecks++;
    if (bus.Ocupado !== 1'b1 || bus.Lo !== 32'd143) begin
      badChecks++;
      $display("FAIL reset_mid_pre: Ocupado=%b Lo=%h required 1 0000008f", bus.Ocupado, bus.Lo);
    end
    reset = 1'b1;
    #1;
    totalChecks++;
    if (bus.Hi !== 32'd0 || bus.Lo !== 32'd0 || {bus.Ocupado, bus.Pronto, bus.DivZero} !== 3'b000) begin
      badChecks++;
      $display("FAIL reset_mid_async: Hi=%h Lo=%h flags=%b required 0 0 000", bus.Hi, bus.Lo, {bus.Ocupado, bus.Pronto, bus.DivZero});
    end
    @(negedge clock);
    reset = 1'b0;
    late = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (bus.Pronto || bus.Ocupado) late++;
    end
    totalChecks++;
    if (late !== 0) begin
      badChecks++;
      $display("FAIL reset_mid_discard: busy/pronto cycles=%0d required 0", late);
    end
    runOp(32'd3, 32'd4, 1'b1, 1'b0, 0, 0, lat, ocu, pr, dz);
    totalChecks++;
    if (bus.Hi !== 32'd0 || bus.Lo !== 32'd12 || lat !== 33) begin
      badChecks++;
      $display("FAIL reset_mid_after: Hi=%h Lo=%h latency=%0d required 0 0000000c 33", bus.Hi, bus.Lo, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, ocu, pr;
    logic dz;
    runOp(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 0, 0, lat1, ocu, pr, dz);
    totalChecks++;
    if (bus.Hi !== 32'd0 || bus.Lo !== 32'd1) begin
      badChecks++;
      $display("FAIL b2b_first: Hi=%h Lo=%h required 0 00000001", bus.Hi, bus.Lo);
    end
    runOp(32'd20, 32'hFFFFFFFA, 1'b0, 1'b1, 0, 0, lat2, ocu, pr, dz);
    totalChecks++;
    if (bus.Hi !== 32'd2 || bus.Lo !== 32'hFFFFFFFD || lat1 !== 33 || lat2 !== 33) begin
      badChecks++;
      $display("FAIL b2b_second: Hi=%h Lo=%h lat=%0d/%0d required 00000002 fffffffd 33/33", bus.Hi, bus.Lo, lat1, lat2);
    end
  endtask

  initial begin
    bus.A = '0;
    bus.B = '0;
    bus.IniciaMult = 1'b0;
    bus.IniciaDiv = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    test_reset();
    reset = 1'b0;
    @(negedge clock);
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_overlap();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end
endmodule
